// File: rtl/multi_ch_capture_ctrl.sv
// multi_ch_capture_ctrl
//   N-channel ADC capture engine. Captures a programmable number of points into an
//   internal buffer, optionally averaging 2^k samples per point. Captured points are
//   read back through a pull-style, auto-incrementing readout port.
//
// Ports
//   clk_i           single clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   sample_valid_i  strobe qualifying sample_data_i
//   sample_data_i   packed channel samples, ch0 in the LSBs
//   cfg_points_i    points to capture, latched on an accepted start
//   cfg_avg_log2_i  averaging exponent k, latched on an accepted start
//   start_i         begin a capture (from IDLE or DONE)
//   abort_i         stop capture or readout, return to IDLE
//   rd_req_i        request the next captured point (DONE only)
//   rd_data_o       readout word, held between pulses
//   rd_valid_o      one-cycle pulse, one cycle after an accepted rd_req_i
//   rd_last_o       flags the final captured point, together with rd_valid_o
//   busy_o          capture in progress
//   done_o          capture complete, readout available
//   count_o         points written in the current/last capture
module multi_ch_capture_ctrl #(
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned AVG_LOG2_MAX = 4,
    localparam int unsigned AW          = $clog2(DEPTH),
    localparam int unsigned CW          = $clog2(AVG_LOG2_MAX + 1),
    localparam int unsigned DW          = NUM_CH * ADC_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          sample_valid_i,
    input  logic [DW-1:0] sample_data_i,
    input  logic [AW:0]   cfg_points_i,
    input  logic [CW-1:0] cfg_avg_log2_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          rd_req_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          rd_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned AccW = ADC_WIDTH + AVG_LOG2_MAX;
    // Avg counter must hold 2^AVG_LOG2_MAX - 1; one spare bit keeps the 1 << k mask exact.
    localparam int unsigned ACW  = AVG_LOG2_MAX + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [AW:0]                   points_q, points_d;
    logic [CW-1:0]                 k_q, k_d;
    logic [AW:0]                   count_q, count_d;
    logic [ACW-1:0]                avg_cnt_q, avg_cnt_d;
    logic [NUM_CH-1:0][AccW-1:0]   acc_q, acc_d;
    logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic                          rd_valid_q, rd_valid_d;
    logic                          rd_last_q, rd_last_d;
    logic [DW-1:0]                 rd_data_q, rd_data_d;

    logic [DW-1:0]                 mem_q [DEPTH];

    logic [NUM_CH-1:0][AccW-1:0]   sum;
    logic [NUM_CH-1:0][AccW-1:0]   shifted;
    logic [DW-1:0]                 wr_word;
    logic                          wr_en;
    logic [ACW-1:0]                avg_tgt;
    logic [AW:0]                   pts_clamped;
    logic [CW-1:0]                 k_clamped;
    logic                          rd_accept;
    logic                          rd_is_last;
    logic                          begin_cap;

    always_comb begin
        pts_clamped = (cfg_points_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_points_i;
        k_clamped   = (cfg_avg_log2_i > CW'(AVG_LOG2_MAX)) ? CW'(AVG_LOG2_MAX) : cfg_avg_log2_i;
        avg_tgt     = (ACW'(1) << k_q) - ACW'(1);
    end

    // Running sum including the current sample; the shifted value always fits ADC_WIDTH
    // because 2^k samples of ADC_WIDTH bits sum to less than 2^(ADC_WIDTH+k).
    always_comb begin
        sum     = '0;
        shifted = '0;
        wr_word = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            sum[c]     = acc_q[c] + AccW'(sample_data_i[c*ADC_WIDTH +: ADC_WIDTH]);
            shifted[c] = sum[c] >> k_q;
            wr_word[c*ADC_WIDTH +: ADC_WIDTH] = shifted[c][ADC_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        points_d   = points_q;
        k_d        = k_q;
        count_d    = count_q;
        avg_cnt_d  = avg_cnt_q;
        acc_d      = acc_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;
        begin_cap  = 1'b0;

        // Readout is decided on the current state so a read issued alongside start/abort
        // still produces its rd_valid_o.
        rd_accept  = (state_q == StDone) && rd_req_i && (count_q != '0);
        rd_is_last = ({1'b0, rd_ptr_q} == (count_q - (AW+1)'(1)));
        if (rd_accept) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_last_d  = rd_is_last;
            rd_ptr_d   = rd_is_last ? '0 : rd_ptr_q + AW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    begin_cap = 1'b1;
                end
            end
            StCapture: begin
                if (sample_valid_i) begin
                    if (avg_cnt_q == avg_tgt) begin
                        wr_en     = 1'b1;
                        count_d   = count_q + (AW+1)'(1);
                        acc_d     = '0;
                        avg_cnt_d = '0;
                        if (count_d == points_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        acc_d     = sum;
                        avg_cnt_d = avg_cnt_q + ACW'(1);
                    end
                end
                // The final write above still lands and is counted when abort coincides.
                if (abort_i) begin
                    state_d   = StIdle;
                    acc_d     = '0;
                    avg_cnt_d = '0;
                    rd_ptr_d  = '0;
                end
            end
            StDone: begin
                if (abort_i) begin
                    state_d  = StIdle;
                    rd_ptr_d = '0;
                end else if (start_i) begin
                    begin_cap = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (begin_cap) begin
            points_d  = pts_clamped;
            k_d       = k_clamped;
            count_d   = '0;
            acc_d     = '0;
            avg_cnt_d = '0;
            rd_ptr_d  = '0;
            state_d   = (pts_clamped == '0) ? StDone : StCapture;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            points_q   <= '0;
            k_q        <= '0;
            count_q    <= '0;
            avg_cnt_q  <= '0;
            acc_q      <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            points_q   <= points_d;
            k_q        <= k_d;
            count_q    <= count_d;
            avg_cnt_q  <= avg_cnt_d;
            acc_q      <= acc_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Buffer has no reset; count_q doubles as the write pointer.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= wr_word;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    assign busy_o     = (state_q == StCapture);
    assign done_o     = (state_q == StDone);
    assign count_o    = count_q;

endmodule
